uart_time_setter: RTL and testbench

Serial time-set receiver for the digital clock. Receives an ASCII command `Thhmmss<CR>` on a UART line (8N1), validates it as BCD time, and drives the clock's parallel-load interface: an 8-bit BCD data bus plus a one-hot load select for the second, minute and hour counters. It lets a host PC set the time in place of the S1/S0/Set switches. It is the writer side of the counters' `Load`/`D` load port.

---
 rtl/uart_time_setter.sv | 275 +++++++++++++++++++++++++++
 tb/tb_uart_time_setter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_time_setter.sv
// UART "Thhmmss<CR>" time-set receiver: validates BCD time and drives the clock
// counters' one-hot parallel-load port (seconds, then minutes, then hours).
module uart_time_setter #(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned BAUD   = 9600,
   parameter int unsigned HOLD   = 16
) (
   input  logic       clk,
   input  logic       nCLR,
   input  logic       rxd,
   output logic [7:0] D,
   output logic [2:0] Load,
   output logic       busy,
   output logic       done,
   output logic       err
);
   localparam int unsigned BITPER = CLK_HZ / BAUD;
   localparam int unsigned HALF   = BITPER / 2;
   localparam int unsigned CNT_W  = $clog2(BITPER + 1);
   localparam int unsigned HLD_W  = $clog2(HOLD + 1);

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   localparam logic [1:0] P_WAIT = 2'd0;
   localparam logic [1:0] P_DIG  = 2'd1;
   localparam logic [1:0] P_CR   = 2'd2;

   localparam logic [1:0] L_IDLE = 2'd0;
   localparam logic [1:0] L_SEC  = 2'd1;
   localparam logic [1:0] L_MIN  = 2'd2;
   localparam logic [1:0] L_HOUR = 2'd3;

   localparam logic [7:0] CH_T  = 8'h54;
   localparam logic [7:0] CH_CR = 8'h0D;

   logic             rx_s1_q, rx_s2_q, rx_s3_q;
   logic [1:0]       rx_state_q, rx_state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       sh_q, sh_d;
   logic             brk_q, brk_d;
   logic [7:0]       byte_q, byte_d;
   logic             stb_q, stb_d;
   logic             frame_err_c;

   logic [1:0]       p_state_q, p_state_d;
   logic [2:0]       idx_q, idx_d;
   logic [5:0][3:0]  dig_q, dig_d;

   logic [1:0]       l_state_q, l_state_d;
   logic [HLD_W-1:0] hcnt_q, hcnt_d;
   logic [23:0]      tm_q, tm_d;
   logic [7:0]       d_q, d_d;
   logic [2:0]       load_q, load_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             err_pend_q, err_pend_d;

   logic [23:0]      time_c;
   logic             range_ok_c;
   logic             is_digit_c;
   logic             err_ev_c;
   logic             err_any_c;
   logic             start_c;

   assign time_c     = {dig_q[0], dig_q[1], dig_q[2], dig_q[3], dig_q[4], dig_q[5]};
   assign range_ok_c = (time_c[23:16] <= 8'h23) && (time_c[15:8] <= 8'h59) &&
                       (time_c[7:0] <= 8'h59);
   assign is_digit_c = (byte_q >= 8'h30) && (byte_q <= 8'h39);

   // Byte receiver: mid-bit sampling, framing-error recovery waits for idle line
   always_comb begin
      rx_state_d  = rx_state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      sh_d        = sh_q;
      brk_d       = brk_q;
      byte_d      = byte_q;
      stb_d       = 1'b0;
      frame_err_c = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_s3_q && !rx_s2_q) begin
               rx_state_d = RX_START;
               cnt_d      = '0;
            end
         end
         RX_START: begin
            if (cnt_q == CNT_W'(HALF - 1)) begin
               cnt_d      = '0;
               bit_d      = '0;
               rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RX_DATA: begin
            if (cnt_q == CNT_W'(BITPER - 1)) begin
               cnt_d = '0;
               sh_d  = {rx_s2_q, sh_q[7:1]};
               if (bit_q == 3'd7) rx_state_d = RX_STOP;
               else               bit_d = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            if (brk_q) begin
               if (rx_s2_q) begin
                  brk_d      = 1'b0;
                  rx_state_d = RX_IDLE;
               end
            end else if (cnt_q == CNT_W'(BITPER - 1)) begin
               cnt_d = '0;
               if (rx_s2_q) begin
                  stb_d      = 1'b1;
                  byte_d     = sh_q;
                  rx_state_d = RX_IDLE;
               end else begin
                  frame_err_c = 1'b1;
                  brk_d       = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   // Command parser and load sequencer
   always_comb begin
      p_state_d = p_state_q;
      idx_d     = idx_q;
      dig_d     = dig_q;
      l_state_d = l_state_q;
      hcnt_d    = hcnt_q;
      tm_d      = tm_q;
      d_d       = d_q;
      load_d    = load_q;
      done_d    = 1'b0;
      start_c   = 1'b0;
      err_ev_c  = frame_err_c;

      if (l_state_q != L_IDLE) begin
         if (hcnt_q == HLD_W'(HOLD - 1)) begin
            hcnt_d = '0;
            case (l_state_q)
               L_SEC: begin
                  l_state_d = L_MIN;
                  d_d       = tm_q[15:8];
                  load_d    = 3'b010;
               end
               L_MIN: begin
                  l_state_d = L_HOUR;
                  d_d       = tm_q[23:16];
                  load_d    = 3'b100;
               end
               default: begin
                  l_state_d = L_IDLE;
                  d_d       = 8'h00;
                  load_d    = 3'b000;
                  done_d    = 1'b1;
               end
            endcase
         end else begin
            hcnt_d = hcnt_q + HLD_W'(1);
         end
      end

      if (frame_err_c) begin
         p_state_d = P_WAIT;
      end else if (stb_q) begin
         if (byte_q == CH_T) begin
            p_state_d = P_DIG;
            idx_d     = '0;
         end else begin
            case (p_state_q)
               P_DIG: begin
                  if (is_digit_c) begin
                     for (int i = 0; i < 6; i++)
                        if (idx_q == 3'(i)) dig_d[i] = byte_q[3:0];
                     if (idx_q == 3'd5) p_state_d = P_CR;
                     else               idx_d = idx_q + 3'd1;
                  end else begin
                     err_ev_c  = 1'b1;
                     p_state_d = P_WAIT;
                  end
               end
               P_CR: begin
                  p_state_d = P_WAIT;
                  if (byte_q == CH_CR && range_ok_c && l_state_q == L_IDLE)
                     start_c = 1'b1;
                  else
                     err_ev_c = 1'b1;
               end
               default: ;
            endcase
         end
      end

      if (start_c) begin
         l_state_d = L_SEC;
         hcnt_d    = '0;
         tm_d      = time_c;
         d_d       = time_c[7:0];
         load_d    = 3'b001;
      end
   end

   // An error that lands on the done cycle is deferred by one clock
   assign err_any_c  = err_ev_c | err_pend_q;
   assign err_d      = err_any_c & ~done_d;
   assign err_pend_d = err_any_c & done_d;
   assign busy_d     = (l_state_d != L_IDLE);

   always_ff @(posedge clk or negedge nCLR) begin
      if (!nCLR) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_s3_q    <= 1'b1;
         rx_state_q <= RX_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         sh_q       <= '0;
         brk_q      <= 1'b0;
         byte_q     <= '0;
         stb_q      <= 1'b0;
         p_state_q  <= P_WAIT;
         idx_q      <= '0;
         dig_q      <= '0;
         l_state_q  <= L_IDLE;
         hcnt_q     <= '0;
         tm_q       <= '0;
         d_q        <= '0;
         load_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_pend_q <= 1'b0;
      end else begin
         rx_s1_q    <= rxd;
         rx_s2_q    <= rx_s1_q;
         rx_s3_q    <= rx_s2_q;
         rx_state_q <= rx_state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         sh_q       <= sh_d;
         brk_q      <= brk_d;
         byte_q     <= byte_d;
         stb_q      <= stb_d;
         p_state_q  <= p_state_d;
         idx_q      <= idx_d;
         dig_q      <= dig_d;
         l_state_q  <= l_state_d;
         hcnt_q     <= hcnt_d;
         tm_q       <= tm_d;
         d_q        <= d_d;
         load_q     <= load_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_pend_q <= err_pend_d;
      end
   end

   assign D    = d_q;
   assign Load = load_q;
   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;
endmodule

// File: tb/tb_uart_time_setter.sv
// Directed bench for uart_time_setter: command table plus framing and reset sequences.
module tb_uart_time_setter;
   localparam int unsigned CLK_HZ = 160;
   localparam int unsigned BAUD   = 10;
   localparam int unsigned HOLD   = 16;
   localparam int unsigned BITPER = CLK_HZ / BAUD;
   localparam int          NV     = 11;
   localparam logic [7:0]  CR     = 8'h0D;

   logic       clk  = 1'b0;
   logic       nCLR = 1'b0;
   logic       rxd  = 1'b1;
   logic [7:0] D;
   logic [2:0] Load;
   logic       busy, done, err;

   uart_time_setter #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .HOLD(HOLD)) dut (
      .clk(clk), .nCLR(nCLR), .rxd(rxd),
      .D(D), .Load(Load), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int         n_err = 0, n_done = 0, len_s = 0, len_m = 0, len_h = 0, n_viol = 0;
   logic [7:0] cap_s = 8'h00, cap_m = 8'h00, cap_h = 8'h00, prev_d = 8'h00;
   logic [2:0] prev_load = 3'b000;
   logic       mon_en = 1'b1;
   int         n_vec = 0, n_bad = 0;

   function automatic bit proto_bad(input logic [2:0] pl, input logic [7:0] pd,
                                    input logic [2:0] l, input logic [7:0] d,
                                    input logic b, input logic dn, input logic e);
      bit bad = 1'b0;
      if (e && dn) bad = 1'b1;
      if (!(l inside {3'b000, 3'b001, 3'b010, 3'b100})) bad = 1'b1;
      if (b != (l != 3'b000)) bad = 1'b1;
      if (l == 3'b000 && d != 8'h00) bad = 1'b1;
      if (l == pl && d != pd) bad = 1'b1;
      if (l != pl && !((pl == 3'b000 && l == 3'b001) || (pl == 3'b001 && l == 3'b010) ||
                       (pl == 3'b010 && l == 3'b100) || (pl == 3'b100 && l == 3'b000)))
         bad = 1'b1;
      if (dn != (pl == 3'b100 && l == 3'b000)) bad = 1'b1;
      return bad;
   endfunction

   // Output monitor: pulse counts, per-phase lengths and captured load data
   always @(negedge clk) begin
      if (err)  n_err  <= n_err + 1;
      if (done) n_done <= n_done + 1;
      if (Load == 3'b001) begin len_s <= len_s + 1; cap_s <= D; end
      if (Load == 3'b010) begin len_m <= len_m + 1; cap_m <= D; end
      if (Load == 3'b100) begin len_h <= len_h + 1; cap_h <= D; end
      if (mon_en && nCLR && proto_bad(prev_load, prev_d, Load, D, busy, done, err))
         n_viol <= n_viol + 1;
      prev_load <= Load;
      prev_d    <= D;
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      repeat (BITPER) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (BITPER) @(negedge clk);
      end
      rxd = stop;
      repeat (BITPER) @(negedge clk);
      rxd = 1'b1;
   endtask

   task automatic send_cmd(input logic [8*11-1:0] cmd, input int n);
      for (int i = 0; i < n; i++) send_byte(cmd[8*(n-1-i) +: 8], 1'b1);
   endtask

   // Sends a command and checks the resulting pulses and (if accepted) the loads
   task automatic run_cmd(input string tag, input logic [8*11-1:0] cmd, input int n,
                          input int e_err, input int e_done,
                          input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
      int b_err, b_done, b_s, b_m, b_h;
      b_err = n_err; b_done = n_done; b_s = len_s; b_m = len_m; b_h = len_h;
      send_cmd(cmd, n);
      repeat (3 * HOLD + 2 * BITPER) @(negedge clk);
      check({tag, " err"}, n_err - b_err, e_err);
      check({tag, " done"}, n_done - b_done, e_done);
      if (e_done != 0) begin
         check({tag, " ss"}, int'(cap_s), int'(ss));
         check({tag, " mm"}, int'(cap_m), int'(mm));
         check({tag, " hh"}, int'(cap_h), int'(hh));
         check({tag, " sec len"}, len_s - b_s, HOLD);
         check({tag, " min len"}, len_m - b_m, HOLD);
         check({tag, " hour len"}, len_h - b_h, HOLD);
      end else begin
         check({tag, " no load"}, (len_s - b_s) + (len_m - b_m) + (len_h - b_h), 0);
      end
   endtask

   typedef struct {
      logic [8*11-1:0] cmd;
      int              n;
      int              e_err;
      int              e_done;
      logic [7:0]      hh, mm, ss;
   } vec_t;

   vec_t vt [NV];

   initial begin
      int k;
      int b_err;

      vt[0]  = '{{"T123456", CR},    8,  0, 1, 8'h12, 8'h34, 8'h56};
      vt[1]  = '{{"T235959", CR},    8,  0, 1, 8'h23, 8'h59, 8'h59};
      vt[2]  = '{{"T000000", CR},    8,  0, 1, 8'h00, 8'h00, 8'h00};
      vt[3]  = '{{"T245959", CR},    8,  1, 0, 8'h00, 8'h00, 8'h00};
      vt[4]  = '{{"T126000", CR},    8,  1, 0, 8'h00, 8'h00, 8'h00};
      vt[5]  = '{{"T12T101010", CR}, 11, 0, 1, 8'h10, 8'h10, 8'h10};
      vt[6]  = '{{"T235960", CR},    8,  1, 0, 8'h00, 8'h00, 8'h00};
      vt[7]  = '{{"T12a", CR},       5,  1, 0, 8'h00, 8'h00, 8'h00};
      vt[8]  = '{{"T1234567", CR},   9,  1, 0, 8'h00, 8'h00, 8'h00};
      vt[9]  = '{{"xyT090807", CR},  10, 0, 1, 8'h09, 8'h08, 8'h07};
      vt[10] = '{{"T", CR},          2,  1, 0, 8'h00, 8'h00, 8'h00};

      repeat (3) @(negedge clk);
      check("reset D", int'(D), 0);
      check("reset Load", int'(Load), 0);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset err", int'(err), 0);
      nCLR = 1'b1;
      repeat (2 * BITPER) @(negedge clk);

      for (int v = 0; v < NV; v++)
         run_cmd($sformatf("vec%0d", v), vt[v].cmd, vt[v].n, vt[v].e_err, vt[v].e_done,
                 vt[v].hh, vt[v].mm, vt[v].ss);

      // Stop bit forced low mid-command, then a clean command
      b_err = n_err;
      send_byte(8'h54, 1'b1);
      send_byte(8'h30, 1'b1);
      send_byte(8'h31, 1'b1);
      send_byte(8'h32, 1'b0);
      repeat (2 * BITPER) @(negedge clk);
      check("framing err", n_err - b_err, 1);
      run_cmd("after framing", {"T010203", CR}, 8, 0, 1, 8'h01, 8'h02, 8'h03);

      // Asynchronous reset while minutes are being loaded
      send_cmd({"T123456", CR}, 8);
      k = 0;
      while (Load != 3'b010 && k < 4 * BITPER + 3 * HOLD) begin
         @(negedge clk);
         k++;
      end
      check("reach L_MIN", int'(Load), 3'b010);
      mon_en = 1'b0;
      #2 nCLR = 1'b0;
      #1;
      check("async rst Load", int'(Load), 0);
      check("async rst D", int'(D), 0);
      check("async rst busy", int'(busy), 0);
      @(negedge clk);
      nCLR = 1'b1;
      repeat (4) @(negedge clk);
      mon_en = 1'b1;
      repeat (2 * BITPER) @(negedge clk);
      run_cmd("after reset", {"T205910", CR}, 8, 0, 1, 8'h20, 8'h59, 8'h10);

      check("protocol violations", n_viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
